// File: rtl/prio_arbiter_4.sv
// Four-requester arbiter: fixed 3>2>1>0 priority with hold timeout and per-requester lockout.
// Define ROUND_ROBIN_EN to rotate priority so the last winner becomes lowest priority.
module prio_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_REL  = 2'd2;

  localparam logic             TMO_EN    = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic [N_REQ-1:0] lockout, lockout_n;
  logic [N_REQ-1:0] gnt_n;
  logic [ID_W-1:0]  gnt_id_n;
  logic             busy_n, timeout_n;
  logic [N_REQ-1:0] elig;
  logic [ID_W-1:0]  win;

  assign elig = req & ~lockout;

`ifdef ROUND_ROBIN_EN
  // Rotating priority: search from top downward, modulo 4.
  logic [ID_W-1:0] top;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = top - ID_W'(i);
      if (!found && elig[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Last winner drops to lowest priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      top <= 2'd3;
    end else if (state == ST_IDLE && |elig) begin
      top <= win - 2'd1;
    end
  end
`else
  // Fixed priority encode: highest set index wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (elig[i]) win = ID_W'(i);
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    lockout_n  = lockout & req;
    gnt_n      = gnt;
    gnt_id_n   = gnt_id;
    timeout_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|elig) begin
          state_n    = ST_BUSY;
          gnt_n      = 4'b0001 << win;
          gnt_id_n   = win;
          hold_cnt_n = '0;
        end
      end
      ST_BUSY: begin
        if (!req[gnt_id]) begin
          state_n  = ST_REL;
          gnt_n    = '0;
          gnt_id_n = '0;
        end else if (TMO_EN && hold_cnt == HOLD_LAST) begin
          state_n            = ST_REL;
          gnt_n              = '0;
          gnt_id_n           = '0;
          timeout_n          = 1'b1;
          lockout_n[gnt_id]  = 1'b1;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      ST_REL: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n  = ST_IDLE;
        gnt_n    = '0;
        gnt_id_n = '0;
      end
    endcase
    busy_n = (state_n == ST_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      lockout  <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      lockout  <= lockout_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_prio_arbiter_4.sv
// Bench for prio_arbiter_4: directed scenarios plus random request traffic vs a behavioural model.
module tb_prio_arbiter_4;

  localparam int unsigned MH = 4;
  localparam int unsigned CW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  prio_arbiter_4 #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  // Reference model: owner index (-1 = none), dead-cycle flag, hold count, lockout bits, top.
  int     m_owner = -1;
  bit     m_dead  = 1'b0;
  int     m_held  = 0;
  bit [3:0] m_lock = 4'b0000;
  int     m_top   = 3;
  bit     m_tmo   = 1'b0;

  function automatic int pick(input bit [3:0] e, input int top);
    int t;
    int idx;
    t = top;
`ifndef ROUND_ROBIN_EN
    t = 3;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = (t - k + 4) % 4;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    bit [3:0] el;
    int w;
    if (rst) begin
      m_owner = -1; m_dead = 1'b0; m_held = 0; m_lock = 4'b0000; m_top = 3; m_tmo = 1'b0;
    end else begin
      el    = req & ~m_lock;
      m_tmo = 1'b0;
      for (int i = 0; i < 4; i++) if (!req[i]) m_lock[i] = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_owner = -1; m_dead = 1'b1;
        end else if (MH != 0 && m_held == int'(MH) - 1) begin
          m_tmo = 1'b1; m_lock[m_owner] = 1'b1; m_owner = -1; m_dead = 1'b1;
        end else begin
          m_held++;
        end
      end else if (m_dead) begin
        m_dead = 1'b0;
      end else if (el != 4'b0000) begin
        w       = pick(el, m_top);
        m_owner = w;
        m_held  = 0;
        m_top   = (w + 3) % 4;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  int  grants[$];
  bit  prev_busy = 1'b0;

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check("gnt",     32'(gnt),     32'(eg));
    check("gnt_id",  32'(gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("busy",    32'(busy),    32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_tmo));
    if (busy && !prev_busy) grants.push_back(int'(gnt_id));
    prev_busy = busy;
  endtask

  task automatic cyc(input logic [3:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin : stim
    logic [3:0] r;
    logic [3:0] flip;
    int exp_seq[5];

    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Fixed-priority pick, then hand-over after release.
    cyc(4'b0101, 1'b0);
    check("t1_gnt", 32'(gnt), 32'h4);
    check("t1_id", 32'(gnt_id), 32'd2);
    cyc(4'b0101, 1'b0);
    cyc(4'b0001, 1'b0);
    check("t2_drop", 32'(gnt), 32'd0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    check("t2_regnt", 32'(gnt), 32'h1);
    repeat (3) cyc(4'b0000, 1'b0);

    // Timeout then lockout until the requester drops once.
    repeat (12) cyc(4'b1000, 1'b0);
    check("t3_locked", 32'(gnt), 32'd0);
    cyc(4'b0000, 1'b0);
    cyc(4'b1000, 1'b0);
    check("t3_regnt", 32'(gnt), 32'h8);
    repeat (3) cyc(4'b0000, 1'b0);

    // All request; owner drops for one cycle after two busy cycles.
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
    grants.delete();
    for (int c = 0; c < 24; c++) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held == 1) r[m_owner] = 1'b0;
      cyc(r, 1'b0);
    end
`ifdef ROUND_ROBIN_EN
    exp_seq = '{3, 2, 1, 0, 3};
`else
    exp_seq = '{3, 3, 3, 3, 3};
`endif
    check("t4_ngrants", 32'(grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grants.size()) check("t4_seq", 32'(grants[i]), 32'(exp_seq[i]));
    end
    repeat (3) cyc(4'b0000, 1'b0);

    // Reset during BUSY.
    repeat (3) cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b1);
    check("t5_gnt", 32'(gnt), 32'd0);
    check("t5_tmo", 32'(timeout), 32'd0);
    cyc(4'b0010, 1'b0);
    check("t5_regnt", 32'(gnt), 32'h2);
    repeat (3) cyc(4'b0000, 1'b0);

    // Release on the same edge a timeout would fire.
    repeat (4) cyc(4'b0001, 1'b0);
    cyc(4'b0000, 1'b0);
    check("t6_tmo", 32'(timeout), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    cyc(4'b0001, 1'b0);
    cyc(4'b0001, 1'b0);
    check("t6_regnt", 32'(gnt), 32'h1);
    cyc(4'b0000, 1'b0);

    // Random traffic: bits toggle with low probability so grants last several cycles.
    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      flip = 4'b0000;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 4) == 0);
      r = r ^ flip;
      cyc(r, $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
